uart_io_ctrl: RTL and testbench
===============================

# uart_io_ctrl

Serial port controller behind the CPU's memory-mapped IO decode. It converts the decoder's one-cycle `start` and `clear` strobes into 8N1 UART transmit and receive activity. It reports transmitter occupancy on `busy` and received-byte availability on `ready`; the IO decode packs these two signals into its status word. Received data is returned zero-extended to a full word on `r_data`.

## Interface
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200): clock cycles per serial bit; must be >= 4.
- `WORD`, default 32: CPU word width (from `CPU_Parameter.vh`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  transmit request; sampled on the rising edge.
- `tx_data`  in  WORD  transmit word; only bits [7:0] are used.
- `clear`  in  1  receive-acknowledge strobe, asserted when the CPU reads the data register.
- `rxd`  in  1  serial input; asynchronous, idles at 1.
- `txd`  out  1  serial output; idles at 1.
- `busy`  out  1  transmitter occupied.
- `ready`  out  1  an unread received byte is held.
- `r_data`  out  WORD  last received byte, zero-extended to `{24'b0, byte}`.
- `overrun`  out  1  sticky flag: a byte was received while `ready` was already 1 and not being cleared.

## Operation
- Reset (`rst`=1 at an edge), effective from any state, including mid-frame:
  - `txd`=1, `busy`=0, `ready`=0, `r_data`=0, `overrun`=0.
  - Both FSMs go to IDLE, all counters are 0, and both synchronizer flops are set to 1.
- TX FSM, states IDLE → START → DATA → STOP → IDLE:
  - IDLE: `start`=1 with `busy`=0 latches `tx_data[7:0]` and moves to START.
  - `start` while `busy`=1 is ignored and the data is discarded; nothing is queued.
  - START drives `txd`=0 for C cycles. DATA drives bits 0..7, LSB first, C cycles each. STOP drives `txd`=1 for C cycles.
  - `busy`=1 in every state except IDLE.
- RX path: `rxd` passes through a 2-flop synchronizer; the FSM sees only the synchronized value `rxs`.
- RX FSM, states IDLE → START → DATA → STOP → IDLE:
  - IDLE: `rxs`=0 moves to START.
  - START: wait H = C/2 cycles (integer division), then sample. `rxs`=0 continues to DATA. `rxs`=1 is treated as a glitch and returns to IDLE with no side effects.
  - DATA: sample every C cycles, 8 times, shifting LSB first.
  - STOP: sample after C cycles.
    - `rxs`=1: `r_data` ← byte, `ready` ← 1, return to IDLE. The receiver is rearmed at mid-stop bit.
    - `rxs`=0 (framing error): discard the byte; `ready`, `r_data` and `overrun` are unchanged; return to IDLE.
- `clear`=1 drives `ready` to 0 at the next edge.
- `clear` and a byte completion at the same edge: the new byte wins. `r_data` is updated, `ready` stays 1, and `overrun` is not set.
- Byte completion while `ready`=1 and `clear`=0: `r_data` is overwritten with the new byte and `overrun` is set to 1.
- `overrun` clears only on reset.
- TX and RX are fully independent and may run simultaneously.

## Timing
Notation: C = `CLKS_PER_BIT`; edge 0 is the reference edge in each item.

- TX:
  - `start` accepted at edge 0.
  - After edge 0: `busy`=1, `txd`=0.
  - Data bit i is on `txd` from edge (i+1)·C to edge (i+2)·C.
  - Stop bit runs from edge 9C to edge 10C.
  - After edge 10C: `busy`=0. A `start` sampled at edge 10C is ignored, because `busy` was still 1 during the preceding cycle.
  - Back-to-back frames therefore have a minimum start-to-start spacing of 10C+1 cycles.
- RX, with edge 0 = first edge at which raw `rxd` is sampled 0:
  - `rxs`=0 is visible to the FSM at edge 2.
  - Start bit checked at edge 2+H.
  - Data bit i sampled at edge 2+H+(i+1)·C.
  - Stop bit sampled at edge 2+H+9C; `ready` and `r_data` update at that same edge.
- `clear` latency: 1 edge.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use C=16.

- TX frame: `start`=1 for one cycle with `tx_data`=0x1234_56A5.
  - `txd` sequence (C cycles each) is 0,1,0,1,0,0,1,0,1,1.
  - `busy` is high for exactly 160 cycles.
- Ignored start: a second `start` with `tx_data`=0xFF at edge 50 (mid-frame), then `start` again at edge 160.
  - The frame from the original request is unaffected.
  - The requests at edges 50 and 160 are both dropped; `busy` falls at edge 160 and stays 0.
- RX byte: drive a 0x3C frame on `rxd`.
  - `ready` rises at edge 2+8+144=154; `r_data`=0x0000_003C.
  - `clear` pulse → `ready`=0 one edge later.
- RX overrun and collision:
  - Receive 0x11, then 0x22 without `clear` → `r_data`=0x22, `overrun`=1.
  - Separately, assert `clear` exactly at the stop-sample edge of 0x33 → `ready`=1, `r_data`=0x33, `overrun` unchanged.
- RX glitch and framing error:
  - A 4-cycle low pulse on `rxd` → no `ready`.
  - A 0x55 frame with stop bit = 0 → `ready` and `r_data` unchanged.
  - A valid 0x66 frame immediately afterwards is received correctly.
- Reset mid-operation: assert `rst` during TX data bit 3 and RX data bit 5.
  - Next cycle: `txd`=1, `busy`=0, `ready`=0, `r_data`=0, `overrun`=0.
  - A fresh TX frame and a fresh RX frame afterwards both complete correctly.

Source files
------------

// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: 8N1 UART transmitter/receiver behind the CPU memory-mapped IO decode.
// TX and RX run independently; status (busy/ready/overrun) and data are registered.
module uart_io_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WORD-1:0] tx_data,
    input  logic            clear,
    input  logic            rxd,
    output logic            txd,
    output logic            busy,
    output logic            ready,
    output logic [WORD-1:0] r_data,
    output logic            overrun
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Transmitter state
    state_t        tx_st_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_sh_q;
    logic          txd_q;
    logic          busy_q;

    // Receiver state
    state_t        rx_st_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic          sync1_q;
    logic          sync2_q;
    logic          ready_q;
    logic [7:0]    rdata_q;
    logic          overrun_q;

    logic tx_last;
    logic rx_last;
    logic rx_half;
    logic rxs;
    logic unused_tx_hi;

    assign tx_last      = (tx_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign rx_last      = (rx_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign rx_half      = (rx_cnt_q == CW'(HALF - 1));
    assign rxs          = sync2_q;
    assign unused_tx_hi = ^tx_data[WORD-1:8];

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign ready   = ready_q;
    assign r_data  = {{(WORD-8){1'b0}}, rdata_q};
    assign overrun = overrun_q;

    // TX FSM: start bit, 8 data bits LSB first, stop bit; requests while busy are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st_q  <= S_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (tx_st_q)
                S_IDLE: begin
                    if (start) begin
                        tx_sh_q  <= tx_data[7:0];
                        txd_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        tx_cnt_q <= '0;
                        tx_st_q  <= S_START;
                    end
                end
                S_START: begin
                    if (tx_last) begin
                        tx_cnt_q <= '0;
                        tx_bit_q <= '0;
                        txd_q    <= tx_sh_q[0];
                        tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                        tx_st_q  <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_last) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            tx_st_q <= S_STOP;
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            txd_q    <= tx_sh_q[0];
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_last) begin
                        tx_cnt_q <= '0;
                        busy_q   <= 1'b0;
                        tx_st_q  <= S_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_st_q <= S_IDLE;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous serial input, reset to the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    // RX FSM: mid-bit sampling; a completed byte overrides a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (clear) ready_q <= 1'b0;
            case (rx_st_q)
                S_IDLE: begin
                    if (!rxs) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= S_START;
                    end
                end
                S_START: begin
                    if (rx_half) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_st_q  <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_last) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rxs, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_last) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= S_IDLE;
                        if (rxs) begin
                            rdata_q <= rx_sh_q;
                            ready_q <= 1'b1;
                            if (ready_q && !clear) overrun_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_st_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_io_ctrl.sv
// tb_uart_io_ctrl: directed + randomized checks of uart_io_ctrl against an
// edge-counting reference model (frame timing from plain arithmetic).
module tb_uart_io_ctrl;
    localparam int C = 16;
    localparam int H = C / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] tx_data = '0;
    logic        clear = 1'b0;
    logic        rxd = 1'b1;
    logic        txd, busy, ready, overrun;
    logic [31:0] r_data;

    uart_io_ctrl #(.CLKS_PER_BIT(C), .WORD(32)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .clear(clear),
        .rxd(rxd), .txd(txd), .busy(busy), .ready(ready), .r_data(r_data),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {int e; logic [7:0] b; bit ok;} ev_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_cnt = 0;

    // Reference model state
    bit         tx_act = 0;
    int         m_t0 = 0;
    logic [7:0] m_tb = '0;
    bit         m_ready = 0;
    logic [7:0] m_data = '0;
    bit         m_ovr = 0;
    ev_t        ev_q[$];
    bit         rxq[$];

    function automatic bit m_busy(int n);
        return tx_act && (n >= m_t0) && (n - m_t0 < 10 * C);
    endfunction

    function automatic logic m_txd(int n);
        int j;
        if (!m_busy(n)) return 1'b1;
        j = (n - m_t0) / C;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return m_tb[j-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: update the model from the inputs sampled at this edge, then compare.
    task automatic tick();
        logic st_s, clr_s, rst_s;
        logic [7:0] d_s;
        st_s = start; clr_s = clear; rst_s = rst; d_s = tx_data[7:0];
        @(posedge clk);
        cyc++;
        if (rst_s) begin
            tx_act = 0; m_ready = 0; m_data = '0; m_ovr = 0;
            ev_q.delete(); rxq.delete();
        end else begin
            if (st_s && !m_busy(cyc - 1)) begin
                tx_act = 1; m_t0 = cyc; m_tb = d_s;
            end
            if (ev_q.size() != 0 && ev_q[0].e == cyc) begin
                if (ev_q[0].ok) begin
                    if (m_ready && !clr_s) m_ovr = 1;
                    m_ready = 1;
                    m_data  = ev_q[0].b;
                end else if (clr_s) begin
                    m_ready = 0;
                end
                void'(ev_q.pop_front());
            end else if (clr_s) begin
                m_ready = 0;
            end
        end
        #1;
        rxd = (rxq.size() != 0) ? rxq.pop_front() : 1'b1;
        if (busy === 1'b1) busy_cnt++;
        chk("txd", {31'b0, txd}, {31'b0, m_txd(cyc)});
        chk("busy", {31'b0, busy}, {31'b0, m_busy(cyc)});
        chk("ready", {31'b0, ready}, {31'b0, m_ready});
        chk("r_data", r_data, {24'b0, m_data});
        chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
    endtask

    // Queue a serial frame; returns the edge at which the stop bit is sampled.
    task automatic rx_send(input logic [7:0] b, input bit stop_ok, output int e);
        ev_t ev;
        int e0;
        e0 = cyc + 2 + rxq.size();
        repeat (C) rxq.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (C) rxq.push_back(b[i]);
        repeat (C) rxq.push_back(stop_ok);
        e = e0 + 2 + H + 9 * C;
        ev.e = e; ev.b = b; ev.ok = stop_ok;
        ev_q.push_back(ev);
    endtask

    task automatic rx_idle(input int n);
        repeat (n) rxq.push_back(1'b1);
    endtask

    task automatic wait_rx();
        int n = 0;
        while (ev_q.size() != 0 && n < 1000) begin tick(); n++; end
        chk("rx_timeout", ev_q.size(), 0);
    endtask

    task automatic wait_line();
        int n = 0;
        while (rxq.size() != 0 && n < 1000) begin tick(); n++; end
        chk("line_timeout", rxq.size(), 0);
    endtask

    task automatic wait_tx();
        int n = 0;
        while (m_busy(cyc) && n < 1000) begin tick(); n++; end
        chk("tx_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic tx_start(input logic [7:0] b);
        start = 1'b1;
        tx_data = {$urandom_range(0, 32'hFFFF), 8'h00, b};
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    initial begin
        int e, t0, r;
        logic [7:0] b, tb8;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_txd", {31'b0, txd}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        tick();

        // TX 0xA5 with a mid-frame start (edge 50) and one at edge 160, both dropped
        busy_cnt = 0;
        tx_start(8'hA5);
        tx_data = 32'h1234_56A5;
        t0 = cyc;
        chk("tx_first_txd", {31'b0, txd}, 32'd0);
        while (cyc < t0 + 49) tick();
        start = 1'b1; tx_data = 32'hFF;
        tick();
        start = 1'b0;
        while (cyc < t0 + 159) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tx_end_busy", {31'b0, busy}, 32'd0);
        repeat (2 * C) tick();
        chk("busy_len", busy_cnt, 160);
        chk("tx_idle_txd", {31'b0, txd}, 32'd1);

        // RX 0x3C, left unread; then 0x33 with clear landing on its stop-sample edge
        rx_send(8'h3C, 1'b1, e);
        while (cyc < e - 1) tick();
        chk("rx_pre_ready", {31'b0, ready}, 32'd0);
        tick();
        chk("rx_3c_ready", {31'b0, ready}, 32'd1);
        chk("rx_3c_data", r_data, 32'h0000_003C);
        rx_send(8'h33, 1'b1, e);
        while (cyc < e - 1) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("coll_ready", {31'b0, ready}, 32'd1);
        chk("coll_data", r_data, 32'h33);
        chk("coll_ovr", {31'b0, overrun}, 32'd0);
        pulse_clear();
        chk("clear_lat", {31'b0, ready}, 32'd0);

        // Overrun: two bytes without an acknowledge
        rx_send(8'h11, 1'b1, e);
        rx_send(8'h22, 1'b1, e);
        wait_rx();
        chk("ovr_data", r_data, 32'h22);
        chk("ovr_flag", {31'b0, overrun}, 32'd1);
        pulse_clear();

        // Glitch, framing error, then a good frame after one idle bit time
        repeat (4) rxq.push_back(1'b0);
        rx_idle(3 * C);
        wait_line();
        chk("glitch_ready", {31'b0, ready}, 32'd0);
        rx_send(8'h55, 1'b0, e);
        rx_idle(C);
        wait_rx();
        chk("frm_ready", {31'b0, ready}, 32'd0);
        chk("frm_data", r_data, 32'h22);
        rx_send(8'h66, 1'b1, e);
        wait_rx();
        chk("after_frm", r_data, 32'h66);

        // Random concurrent TX/RX traffic
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom); tb8 = 8'($urandom);
            rx_idle($urandom_range(0, 20));
            rx_send(b, 1'b1, e);
            repeat ($urandom_range(0, 30)) tick();
            tx_start(tb8);
            wait_rx();
            chk("rnd_rx", r_data, {24'b0, b});
            if ($urandom_range(0, 1) == 1) pulse_clear();
            wait_tx();
        end
        wait_line();

        // Reset during TX data bit 3 and RX data bit 5
        r = cyc;
        rx_send(8'hC3, 1'b1, e);
        while (cyc < r + 36) tick();
        tx_start(8'h5A);
        t0 = cyc;
        while (cyc < t0 + 4 * C + 3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_txd", {31'b0, txd}, 32'd1);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_ready", {31'b0, ready}, 32'd0);
        chk("mid_rst_rdata", r_data, 32'd0);
        chk("mid_rst_ovr", {31'b0, overrun}, 32'd0);
        tick();
        b = 8'($urandom); tb8 = 8'($urandom);
        rx_send(b, 1'b1, e);
        tx_start(tb8);
        wait_rx();
        chk("post_rst_rx", r_data, {24'b0, b});
        chk("post_rst_ready", {31'b0, ready}, 32'd1);
        wait_tx();
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
